// File: rtl/ntf_arbiter.sv
// Round-robin merge of NREQ functional-unit results onto the single commit
// notification port; each unit owns a one-entry holding slot.
module ntf_arbiter #(
  parameter  int WIDTH = 32,
  parameter  int SIZE  = 8,
  parameter  int NREQ  = 3,
  localparam int BITS  = $clog2(SIZE)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [3*NREQ-1:0]     req_exc,
  input  logic [WIDTH*NREQ-1:0] req_val,
  input  logic [BITS*NREQ-1:0]  req_at,
  output logic                  ntf,
  output logic [2:0]            exc_n,
  output logic [WIDTH-1:0]      val,
  output logic [BITS-1:0]       at,
  output logic                  busy
);

  localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]  held_q, held_d;
  logic [2:0]       slot_exc_q [NREQ];
  logic [2:0]       slot_exc_d [NREQ];
  logic [WIDTH-1:0] slot_val_q [NREQ];
  logic [WIDTH-1:0] slot_val_d [NREQ];
  logic [BITS-1:0]  slot_at_q  [NREQ];
  logic [BITS-1:0]  slot_at_d  [NREQ];

  logic [LW-1:0]    last_q, last_d;
  logic             ntf_q, ntf_d;
  logic [2:0]       exc_n_q, exc_n_d;
  logic [WIDTH-1:0] val_q, val_d;
  logic [BITS-1:0]  at_q, at_d;

  logic [NREQ-1:0]  grant;
  logic [NREQ-1:0]  accept;
  logic             win_valid;
  logic [LW-1:0]    win_idx;
  logic             fire;

  // Search starts just after the last winner, wrapping around.
  always_comb begin
    grant     = '0;
    win_valid = 1'b0;
    win_idx   = '0;
    for (int i = 1; i <= NREQ; i++) begin
      if (!win_valid && held_q[(int'(last_q) + i) % NREQ]) begin
        win_valid = 1'b1;
        win_idx   = LW'((int'(last_q) + i) % NREQ);
      end
    end
    if (win_valid) grant[win_idx] = 1'b1;
  end

  // A slot being drained this edge can be refilled on the same edge.
  assign req_ready = {NREQ{~flush}} & (~held_q | grant);
  assign accept    = req_valid & req_ready;
  assign fire      = win_valid & ~flush;

  always_comb begin
    held_d = held_q;
    for (int k = 0; k < NREQ; k++) begin
      slot_exc_d[k] = slot_exc_q[k];
      slot_val_d[k] = slot_val_q[k];
      slot_at_d[k]  = slot_at_q[k];
      held_d[k]     = ~flush & (accept[k] | (held_q[k] & ~grant[k]));
      if (accept[k]) begin
        slot_exc_d[k] = req_exc[3*k +: 3];
        slot_val_d[k] = req_val[WIDTH*k +: WIDTH];
        slot_at_d[k]  = req_at[BITS*k +: BITS];
      end
    end
  end

  always_comb begin
    ntf_d   = fire;
    exc_n_d = exc_n_q;
    val_d   = val_q;
    at_d    = at_q;
    last_d  = last_q;
    if (fire) begin
      exc_n_d = slot_exc_q[win_idx];
      val_d   = slot_val_q[win_idx];
      at_d    = slot_at_q[win_idx];
      last_d  = win_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      held_q  <= '0;
      last_q  <= LW'(NREQ - 1);
      ntf_q   <= 1'b0;
      exc_n_q <= 3'd0;
      val_q   <= '0;
      at_q    <= '0;
    end else begin
      held_q  <= held_d;
      last_q  <= last_d;
      ntf_q   <= ntf_d;
      exc_n_q <= exc_n_d;
      val_q   <= val_d;
      at_q    <= at_d;
    end
  end

  // Slot payload is qualified by held_q, so it needs no reset.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NREQ; k++) begin
      slot_exc_q[k] <= slot_exc_d[k];
      slot_val_q[k] <= slot_val_d[k];
      slot_at_q[k]  <= slot_at_d[k];
    end
  end

  assign ntf   = ntf_q;
  assign exc_n = exc_n_q;
  assign val   = val_q;
  assign at    = at_q;
  assign busy  = |held_q;

endmodule

// File: tb/tb_ntf_arbiter.sv
// Directed bench for ntf_arbiter (NREQ=3, WIDTH=32, SIZE=8).
module tb_ntf_arbiter;

  localparam int WIDTH = 32;
  localparam int NREQ  = 3;
  localparam int BITS  = 3;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  flush;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [3*NREQ-1:0]     req_exc;
  logic [WIDTH*NREQ-1:0] req_val;
  logic [BITS*NREQ-1:0]  req_at;
  logic                  ntf;
  logic [2:0]            exc_n;
  logic [WIDTH-1:0]      val;
  logic [BITS-1:0]       at;
  logic                  busy;

  int checks = 0;
  int errors = 0;

  ntf_arbiter #(.WIDTH(WIDTH), .SIZE(8), .NREQ(NREQ)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_exc(req_exc), .req_val(req_val), .req_at(req_at),
    .ntf(ntf), .exc_n(exc_n), .val(val), .at(at), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input int k, input logic v, input logic [2:0] e,
                       input logic [WIDTH-1:0] d, input logic [BITS-1:0] t);
    req_valid[k]           = v;
    req_exc[3*k +: 3]      = e;
    req_val[WIDTH*k +: WIDTH] = d;
    req_at[BITS*k +: BITS] = t;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    flush = 1'b0;
    req_valid = '0;
    req_exc = '0;
    req_val = '0;
    req_at = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  int w, k, seq0, seq2;

  initial begin
    do_reset();

    // Reset then idle
    for (int i = 0; i < 10; i++) begin
      chk("idle_ntf", 64'(ntf), 64'd0);
      chk("idle_exc", 64'(exc_n), 64'd0);
      chk("idle_at", 64'(at), 64'd0);
      chk("idle_busy", 64'(busy), 64'd0);
      chk("idle_ready", 64'(req_ready), 64'b111);
      step();
    end
    chk("idle_val", 64'(val), 64'd0);
    $display("idle: done");

    // Single unit
    drive(1, 1'b1, 3'd0, 32'h1234, 3'd5);
    step();
    req_valid = '0;
    chk("single_ntf_e0", 64'(ntf), 64'd0);
    chk("single_busy_e0", 64'(busy), 64'd1);
    step();
    chk("single_ntf", 64'(ntf), 64'd1);
    chk("single_val", 64'(val), 64'h1234);
    chk("single_at", 64'(at), 64'd5);
    chk("single_exc", 64'(exc_n), 64'd0);
    chk("single_busy_e1", 64'(busy), 64'd0);
    step();
    chk("single_ntf_off", 64'(ntf), 64'd0);
    $display("single: at=%0d val=%0h", at, val);

    // Three-way collision, two bursts
    do_reset();
    for (int b = 0; b < 2; b++) begin
      for (int u = 0; u < 3; u++)
        drive(u, 1'b1, 3'd0, 32'(100 + 3*b + u), 3'(1 + 3*b + u));
      step();
      req_valid = '0;
      for (int u = 0; u < 3; u++) begin
        step();
        chk("coll_ntf", 64'(ntf), 64'd1);
        chk("coll_at", 64'(at), 64'(1 + 3*b + u));
        chk("coll_val", 64'(val), 64'(100 + 3*b + u));
        $display("collision burst %0d: at=%0d", b, at);
      end
      chk("coll_busy", 64'(busy), 64'd0);
      step();
      chk("coll_ntf_off", 64'(ntf), 64'd0);
    end

    // Streaming units 0 and 2
    do_reset();
    seq0 = 0;
    seq2 = 0;
    drive(0, 1'b1, 3'd0, {16'd0, 16'(seq0)}, 3'(seq0));
    drive(2, 1'b1, 3'd0, {16'd2, 16'(seq2)}, 3'(4 + seq2));
    chk("strm_ready_e0", 64'(req_ready), 64'b111);
    step();
    seq0 = 1;
    seq2 = 1;
    drive(0, 1'b1, 3'd0, {16'd0, 16'(seq0)}, 3'(seq0));
    drive(2, 1'b1, 3'd0, {16'd2, 16'(seq2)}, 3'(4 + seq2));
    for (int i = 1; i <= 10; i++) begin
      w = (i % 2 == 1) ? 0 : 2;
      k = (i - 1) / 2;
      if (i <= 8)
        chk("strm_ready", 64'(req_ready), (w == 0) ? 64'b011 : 64'b110);
      step();
      chk("strm_ntf", 64'(ntf), 64'd1);
      chk("strm_val", 64'(val), {32'd0, 16'(w), 16'(k)});
      chk("strm_at", 64'(at), 64'(((w == 0) ? 0 : 4) + k) & 64'd7);
      $display("stream %0d: unit=%0d at=%0d val=%0h", i, w, at, val);
      if (i <= 8) begin
        if (w == 0) begin
          seq0++;
          drive(0, 1'b1, 3'd0, {16'd0, 16'(seq0)}, 3'(seq0));
        end else begin
          seq2++;
          drive(2, 1'b1, 3'd0, {16'd2, 16'(seq2)}, 3'(4 + seq2));
        end
      end
      if (i == 8) req_valid = '0;
    end
    step();
    chk("strm_ntf_end", 64'(ntf), 64'd0);
    chk("strm_busy_end", 64'(busy), 64'd0);

    // Exception pass-through
    do_reset();
    drive(2, 1'b1, 3'b101, 32'hDEADBEEF, 3'd7);
    step();
    req_valid = '0;
    step();
    chk("exc_ntf", 64'(ntf), 64'd1);
    chk("exc_code", 64'(exc_n), 64'd5);
    chk("exc_val", 64'(val), 64'hDEADBEEF);
    chk("exc_at", 64'(at), 64'd7);
    $display("exception: exc_n=%0d val=%0h at=%0d", exc_n, val, at);

    // Flush drops held results
    do_reset();
    drive(0, 1'b1, 3'd0, 32'hA0, 3'd2);
    drive(1, 1'b1, 3'd0, 32'hA1, 3'd3);
    step();
    req_valid = '0;
    flush = 1'b1;
    #1;
    chk("flush_ready", 64'(req_ready), 64'd0);
    chk("flush_busy_pre", 64'(busy), 64'd1);
    step();
    flush = 1'b0;
    chk("flush_ntf", 64'(ntf), 64'd0);
    chk("flush_busy", 64'(busy), 64'd0);
    for (int i = 0; i < 4; i++) begin
      chk("flush_quiet", 64'(ntf), 64'd0);
      step();
    end
    drive(1, 1'b1, 3'd0, 32'h55, 3'd6);
    step();
    req_valid = '0;
    chk("post_flush_e0", 64'(ntf), 64'd0);
    step();
    chk("post_flush_ntf", 64'(ntf), 64'd1);
    chk("post_flush_at", 64'(at), 64'd6);
    chk("post_flush_val", 64'(val), 64'h55);
    $display("flush: post-flush at=%0d val=%0h", at, val);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
